// File: rtl/usb2_ulpi_regq.sv
// ============================================================================
// Module   : usb2_ulpi_regq
// Brief    : Queued ULPI register-access engine. Supports immediate and
//            extended addressing, bus arbitration, DIR pre-emption with retry,
//            access timeout and RX_CMD capture.
//            Optional feature macro: ULPI_REG_READBACK_EN (write readback and
//            compare).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb2_ulpi_regq #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic       phy_clk,
    input  logic       reset,
    input  logic [7:0] phy_d_in,
    output logic [7:0] phy_d_out,
    output logic       phy_d_oe,
    input  logic       phy_dir,
    input  logic       phy_nxt,
    output logic       phy_stp,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_valid,
    output logic       busy
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        IDLE, WAIT_GNT, CMD, EXT, WDATA, STP, TURN, RDATA, ABORT
    } state_t;

    state_t        state;
    logic          dir_q;
    logic          ready_en;
    logic [16:0]   mem [QUEUE_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          head_write;
    logic [7:0]    head_addr;
    logic [7:0]    head_wdata;
    logic          eff_write;
    logic          is_ext;
    logic [5:0]    addr_field;
    logic [7:0]    tx_cmd;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;
    logic          in_tx;
    logic          timeout;
    logic          abort_now;
    logic          fail_now;
`ifdef ULPI_REG_READBACK_EN
    logic          rb_phase;
    logic [7:0]    rb_mask;
`endif

    // FIFO status and head-of-queue decode
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign req_ready  = ~full & ready_en;
    assign push       = req_valid & req_ready;
    assign head_write = mem[rd_ptr[AW-1:0]][16];
    assign head_addr  = mem[rd_ptr[AW-1:0]][15:8];
    assign head_wdata = mem[rd_ptr[AW-1:0]][7:0];

`ifdef ULPI_REG_READBACK_EN
    // The readback pass of a write is issued as a read of the same address.
    assign eff_write  = head_write & ~rb_phase;
    // The Function Control Reset bit self-clears, so it is ignored in the compare.
    assign rb_mask    = (head_addr == 8'h04) ? 8'hDF : 8'hFF;
`else
    assign eff_write  = head_write;
`endif

    assign is_ext     = (head_addr >= 8'h2F);
    assign addr_field = is_ext ? 6'h2F : head_addr[5:0];
    assign tx_cmd     = {eff_write ? 2'b10 : 2'b11, addr_field};

    assign in_tx      = (state == CMD) || (state == EXT) || (state == WDATA);
    assign timeout    = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign abort_now  = phy_dir && (in_tx || ((state == TURN) && phy_nxt));
    assign fail_now   = !phy_dir && timeout && ((state == TURN) || (in_tx && !phy_nxt));

    // Link drives the pad only when the PHY has not owned it this or last cycle.
    assign phy_d_oe   = ~phy_dir & ~dir_q;
    assign busy       = ~empty | (state != IDLE);

    // DIR history; starting high keeps the pad released until the first clock.
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            dir_q    <= 1'b1;
            ready_en <= 1'b0;
        end else begin
            dir_q    <= phy_dir;
            ready_en <= 1'b1;
        end
    end

    // Request storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge phy_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {req_write, req_addr, req_wdata};
    end

    // Write pointer advances on every accepted request.
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset)     wr_ptr <= '0;
        else if (push) wr_ptr <= wr_ptr + 1'b1;
    end

    // Register-access sequencer with registered pad and response outputs.
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phy_d_out <= 8'h00;
            phy_stp   <= 1'b0;
            bus_req   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 8'h00;
            rd_ptr    <= '0;
            retry_cnt <= '0;
            timer     <= '0;
`ifdef ULPI_REG_READBACK_EN
            rb_phase  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            phy_stp   <= 1'b0;
            timer     <= (in_tx || (state == TURN)) ? timer + 1'b1 : '0;
            if (fail_now) begin
                // No answer from the PHY: give up on this request.
                state     <= IDLE;
                phy_d_out <= 8'h00;
                bus_req   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_error <= 1'b1;
                rsp_rdata <= 8'h00;
                rd_ptr    <= rd_ptr + 1'b1;
                retry_cnt <= '0;
                timer     <= '0;
`ifdef ULPI_REG_READBACK_EN
                rb_phase  <= 1'b0;
`endif
            end else if (abort_now) begin
                // PHY took the bus: release everything and retry later.
                state     <= ABORT;
                phy_d_out <= 8'h00;
                bus_req   <= 1'b0;
                retry_cnt <= retry_cnt + 1'b1;
                timer     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!empty && !phy_dir) begin
                            bus_req <= 1'b1;
                            state   <= WAIT_GNT;
                        end
                    end
                    WAIT_GNT: begin
                        if (bus_gnt && !phy_dir) begin
                            phy_d_out <= tx_cmd;
                            state     <= CMD;
                            timer     <= '0;
                        end
                    end
                    CMD: begin
                        if (phy_nxt) begin
                            timer <= '0;
                            if (is_ext) begin
                                phy_d_out <= head_addr;
                                state     <= EXT;
                            end else if (eff_write) begin
                                phy_d_out <= head_wdata;
                                state     <= WDATA;
                            end else begin
                                phy_d_out <= 8'h00;
                                state     <= TURN;
                            end
                        end
                    end
                    EXT: begin
                        if (phy_nxt) begin
                            timer     <= '0;
                            phy_d_out <= eff_write ? head_wdata : 8'h00;
                            state     <= eff_write ? WDATA : TURN;
                        end
                    end
                    WDATA: begin
                        if (phy_nxt) begin
                            phy_d_out <= 8'h00;
                            phy_stp   <= 1'b1;
                            state     <= STP;
                            timer     <= '0;
                        end
                    end
                    STP: begin
`ifdef ULPI_REG_READBACK_EN
                        rb_phase  <= 1'b1;
                        phy_d_out <= {2'b11, addr_field};
                        state     <= CMD;
`else
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 8'h00;
                        bus_req   <= 1'b0;
                        rd_ptr    <= rd_ptr + 1'b1;
                        retry_cnt <= '0;
                        state     <= IDLE;
`endif
                    end
                    TURN: begin
                        if (phy_dir) begin
                            state <= RDATA;
                            timer <= '0;
                        end
                    end
                    RDATA: begin
`ifdef ULPI_REG_READBACK_EN
                        if (rb_phase) rsp_error <= |((phy_d_in ^ head_wdata) & rb_mask);
                        rb_phase  <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        rsp_rdata <= phy_d_in;
                        bus_req   <= 1'b0;
                        rd_ptr    <= rd_ptr + 1'b1;
                        retry_cnt <= '0;
                        state     <= IDLE;
                    end
                    ABORT: begin
                        if (!phy_dir) begin
                            state <= IDLE;
                            if (retry_cnt > RW'(MAX_RETRY)) begin
                                rsp_valid <= 1'b1;
                                rsp_error <= 1'b1;
                                rsp_rdata <= 8'h00;
                                rd_ptr    <= rd_ptr + 1'b1;
                                retry_cnt <= '0;
`ifdef ULPI_REG_READBACK_EN
                                rb_phase  <= 1'b0;
`endif
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // RX_CMD capture: a held-DIR byte without NXT that is not register read data.
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            rx_cmd       <= 8'h00;
            rx_cmd_valid <= 1'b0;
        end else begin
            rx_cmd_valid <= 1'b0;
            if (dir_q && phy_dir && !phy_nxt && (state != RDATA)) begin
                rx_cmd       <= phy_d_in;
                rx_cmd_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/usb2_ulpi_regq.md
Name: usb2_ulpi_regq

Overview:
- Parametrised ULPI register-access engine; successor to the single-shot register path in the ULPI link.
- Accepts queued read/write requests from link or debug logic and supports immediate (6-bit) and extended (8-bit) addressing.
- Arbitrates the ULPI bus against the packet path, aborts and retries when the PHY pre-empts with DIR, and captures RX_CMD bytes.
- Sits between the ULPI pins and the link FSM in the phy_clk (60 MHz) domain.

Parameters:
- QUEUE_DEPTH, 4: request FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 255: phy_clk cycles to wait for NXT or DIR before the attempt fails.
- MAX_RETRY, 3: attempts after a DIR pre-emption before rsp_error is returned.

Ports:
- phy_clk  in  1  ULPI 60 MHz clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- phy_d_in  in  8  ULPI data from pad.
- phy_d_out  out  8  ULPI data to pad.
- phy_d_oe  out  1  pad output enable.
- phy_dir  in  1  ULPI DIR.
- phy_nxt  in  1  ULPI NXT.
- phy_stp  out  1  ULPI STP.
- bus_req  out  1  request ULPI bus from the packet-path arbiter.
- bus_gnt  in  1  bus granted; held by the arbiter until bus_req drops.
- req_valid  in  1  request strobe.
- req_ready  out  1  FIFO not full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  read data; 0 for writes.
- rsp_error  out  1  qualifies rsp_valid: timeout or retries exhausted.
- rx_cmd  out  8  last RX_CMD byte.
- rx_cmd_valid  out  1  one-cycle pulse when rx_cmd updates.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values: all outputs 0, except phy_d_oe = 0 and rx_cmd = 8'h00. Reset clears the FIFO, FSM, retry counter and timer.
- Reset asserted mid-transfer: STP is not issued; the PHY recovers through its own timeout.
- Pad control: phy_d_oe = ~phy_dir & ~dir_q, where dir_q is phy_dir registered. This gives one turnaround cycle after DIR falls. phy_d_out is registered.
- FIFO: push on req_valid & req_ready. Push when full is ignored. Simultaneous push and pop are allowed.
- Addressing: req_addr < 8'h2F uses immediate mode. Otherwise extended mode: TX_CMD address field = 6'h2F, followed by an address byte.
- FSM states:
  - IDLE: FIFO non-empty and phy_dir low -> assert bus_req, go to WAIT_GNT.
  - WAIT_GNT: bus_gnt & ~phy_dir -> CMD.
  - CMD: drive {write ? 2'b10 : 2'b11, addr_field}. On NXT -> EXT if extended, else WDATA (write) or TURN (read).
  - EXT: drive req_addr. On NXT -> WDATA or TURN.
  - WDATA: drive data. On NXT -> STP.
  - STP: phy_stp = 1 and phy_d_out = 0 for exactly one cycle; pop FIFO; rsp_valid next cycle.
  - TURN: wait for DIR rising. DIR & ~NXT -> RDATA. DIR & NXT (receive pre-empts the read) -> ABORT.
  - RDATA: latch phy_d_in into rsp_rdata; pop FIFO; rsp_valid; -> IDLE.
  - ABORT: drop bus_req; increment retry counter; wait for DIR low -> IDLE. The request stays at the FIFO head.
- Pre-emption: DIR rising in CMD, EXT or WDATA before NXT -> ABORT. Drive nothing; no STP.
- Retry limit: retry count > MAX_RETRY -> pop the request and respond with rsp_error = 1. The counter clears on every pop.
- Timeout: the timer runs in CMD, EXT, WDATA and TURN and resets on every state change. Reaching TIMEOUT_CYCLES -> pop, rsp_error = 1, bus_req = 0, back to IDLE.
- RX_CMD capture: in any state, a cycle with dir_q & phy_dir & ~phy_nxt that is not RDATA latches rx_cmd and pulses rx_cmd_valid. Bytes of a receive packet (NXT high) are not captured.
- Latency: immediate write, NXT tied high = 4 cycles from grant to rsp_valid. An extended request adds 1 cycle.

Optional Feature:
- Macro: ULPI_REG_READBACK_EN.
- When defined: after STP of every write, the engine issues an internal read of the same address and compares the result with the write data. rsp_valid fires after the readback completes; rsp_error = 1 on mismatch; rsp_rdata = the value read back. Reads of Function Control (8'h04) bit 5 (Reset) are masked in the compare.
- When undefined: the write response follows STP directly and rsp_rdata = 0.

Test Plan:
- Immediate write addr 8'h0A, data 8'h00, NXT answered each byte -> phy_d_out sequence 8'h8A, 8'h00; STP for one cycle; rsp_valid with rsp_error = 0.
- Extended read addr 8'h3C, PHY returns 8'h5A -> 8'hEF then 8'h3C; one turnaround cycle with phy_d_oe = 0; rsp_rdata = 8'h5A.
- DIR rises during CMD before NXT with RX_CMD 8'h4D -> rx_cmd = 8'h4D with pulse; no STP; transaction retries and completes after DIR falls.
- PHY never asserts NXT -> rsp_error = 1 after 255 cycles; FIFO advances to the next request.
- Push 5 requests with QUEUE_DEPTH = 4 -> req_ready = 0 after the 4th; 5th push ignored; 4 responses returned in order.
- DIR & NXT in TURN on every attempt -> 4 aborts, then rsp_error = 1.
